// File: rtl/lzd_normalizer.sv
// Pipelined left-normaliser fed by a leading-zero detector: one log-shifter bit per stage,
// lock-step valid/ready pipe. Define NORM_CHECK_EN to build the LZD-consistency checker (out_err).
module lzd_normalizer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [CNT_W-1:0] in_cnt,
  input  logic             in_zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] out_cnt,
  output logic             out_zero,
  output logic             out_err
);

  logic             r_vld  [CNT_W];
  logic [WIDTH-1:0] r_data [CNT_W];
  logic [CNT_W-1:0] r_cnt  [CNT_W];
  logic             r_zero [CNT_W];
  logic             r_err  [CNT_W];

  logic             w_en;
  logic             w_oor;
  logic [WIDTH-1:0] w_s0_data;
  logic             w_s0_err;

  // Whole pipe advances together; a held output beat freezes every stage behind it.
  assign w_en     = ~r_vld[CNT_W-1] | out_ready;
  assign in_ready = w_en & ~rst;

  // A count can only exceed the data width when WIDTH is not a power of two.
  generate
    if (WIDTH < (2 ** CNT_W)) begin : g_oor
      assign w_oor = (32'(in_cnt) >= WIDTH);
    end else begin : g_no_oor
      assign w_oor = 1'b0;
    end
  endgenerate

  // NOTE: every variable in an always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_s0_data = in_data;
    if (in_zero || w_oor) begin
      w_s0_data = '0;
    end else if (in_cnt[CNT_W-1]) begin
      w_s0_data = in_data << (2 ** (CNT_W - 1));
    end
  end

`ifdef NORM_CHECK_EN
  // Consistent LZD result: the bits from the claimed leading one upward read exactly 1.
  always_comb begin
    w_s0_err = 1'b0;
    if (in_zero) begin
      w_s0_err = |in_data;
    end else if (w_oor) begin
      w_s0_err = 1'b1;
    end else begin
      w_s0_err = ((in_data >> (WIDTH - 1 - 32'(in_cnt))) != WIDTH'(1));
    end
  end
`else
  assign w_s0_err = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments only; the data registers are
  // reset as well because out_data must read 0 after reset, not just out_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < CNT_W; k++) begin
        r_vld[k]  <= 1'b0;
        r_data[k] <= '0;
        r_cnt[k]  <= '0;
        r_zero[k] <= 1'b0;
        r_err[k]  <= 1'b0;
      end
    end else if (w_en) begin
      r_vld[0]  <= in_valid;
      r_data[0] <= w_s0_data;
      r_cnt[0]  <= in_cnt;
      r_zero[0] <= in_zero;
      r_err[0]  <= w_s0_err;
      for (int k = 1; k < CNT_W; k++) begin
        r_vld[k]  <= r_vld[k-1];
        r_data[k] <= r_cnt[k-1][CNT_W-1-k] ? (r_data[k-1] << (2 ** (CNT_W - 1 - k)))
                                           : r_data[k-1];
        r_cnt[k]  <= r_cnt[k-1];
        r_zero[k] <= r_zero[k-1];
        r_err[k]  <= r_err[k-1];
      end
    end
  end

  assign out_valid = r_vld[CNT_W-1];
  assign out_data  = r_data[CNT_W-1];
  assign out_cnt   = r_cnt[CNT_W-1];
  assign out_zero  = r_zero[CNT_W-1];
  assign out_err   = r_err[CNT_W-1];

endmodule
